uart_alu_core: RTL and testbench
================================

// Module: uart_alu_core
// PURPOSE
//  Parametrised successor to the single-byte fixed-adder core: a UART-fed multi-byte ALU controller.
//  Sits between the UART receiver and transmitter in the top level.
//  Receives an opcode byte plus two DATA_W-bit operands (LSB byte first), computes one of six ops,
//  returns the result bytes plus a status byte, with an inter-byte timeout for framing recovery.
// PARAMETERS
//  DATA_W       16     operand/result width; multiple of 8, >= 8; NB = DATA_W/8 bytes per operand
//  TIMEOUT_CYC  10000  max idle cycles between Rx bytes inside a frame before abort
// PORTS
//  CLK          in   1       clock, rising edge
//  RST          in   1       asynchronous, active-low reset
//  Rx_Byte_in   in   8       received byte, valid when Rx_DV_in=1
//  Rx_DV_in     in   1       one-cycle strobe: Rx_Byte_in valid
//  Tx_Done_in   in   1       one-cycle strobe: transmitter finished current byte
//  Tx_DV_out    out  1       one-cycle strobe: start transmitting Tx_Byte_out
//  Tx_Byte_out  out  8       byte to transmit; held stable until Tx_Done_in
//  Busy_out     out  1       1 in any state except IDLE
//  Frame_Err_out out 1       one-cycle pulse on inter-byte timeout abort
//  c_out        out  8       low byte of last computed result (debug LED)
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE; all counters, operands, result, status cleared;
//   Tx_DV_out=0, Tx_Byte_out=0, Busy_out=0, Frame_Err_out=0, c_out=0.
//  States: IDLE -> RECV -> EXE -> SEND -> IDLE.
//  IDLE: on Rx_DV_in latch opcode, byte_cnt=0, tmo_cnt=0, go RECV.
//  RECV: each Rx_DV_in stores byte byte_cnt into A (cnt 0..NB-1) or B (cnt NB..2NB-1), LSB first;
//   tmo_cnt clears on each byte, else increments; after byte 2NB-1 go EXE.
//   tmo_cnt reaching TIMEOUT_CYC-1 with no byte: go IDLE, pulse Frame_Err_out, discard partial frame.
//   Rx_DV_in on the same cycle as the timeout threshold: byte wins, no abort.
//  EXE: exactly one cycle; result and status registered; c_out <= result[7:0]; go SEND.
//  Opcodes (all DATA_W-bit, wrap-around unless noted):
//   0x00 ADD  A+B; carry = carry-out; ovf = signed overflow
//   0x01 SUB  A-B; carry = 1 when no borrow (A>=B unsigned); ovf = signed overflow
//   0x02 AND, 0x03 OR, 0x04 XOR; carry=0, ovf=0
//   0x05 SADD signed saturating add; clamps to 0x7F..F / 0x80..0; ovf=1 iff clamped; carry=0
//   other: bad opcode; operands still consumed; result=0; status bit7=1, bits2:0=0
//  Status byte: {badop, 4'b0, ovf, carry, zero}; zero=1 iff result==0 (0 for bad opcode).
//  SEND: transmits NB result bytes (LSB first), then the status byte: NB+1 bytes per frame.
//   Per byte: drive Tx_Byte_out, pulse Tx_DV_out for 1 cycle, wait for Tx_Done_in, then next byte
//   on the following cycle. After the Tx_Done_in for the status byte go IDLE.
//   No second Tx_DV_out is issued before Tx_Done_in; Tx_Done_in outside a wait is ignored.
//  Rx_DV_in during EXE/SEND is dropped; a new frame starts only from IDLE.
//  Latency: Tx_DV_out for the first result byte asserts 2 cycles after the last operand strobe.
//  Async reset mid-frame (any state) returns to IDLE immediately; no partial byte is resent.
// TESTING (DATA_W=16, Tx_Done_in modelled 5 cycles after each Tx_DV_out)
//  ADD: 00,34,12,01,00 -> Tx 35,12,00; c_out=0x35
//  ADD wrap: 00,FF,FF,01,00 -> Tx 00,00,03 (zero+carry)
//  SADD clamp: 05,F0,7F,00,01 -> Tx FF,7F,04; SUB: 01,05,00,07,00 -> Tx FE,FF,00
//  Bad opcode: 09,11,22,33,44 -> Tx 00,00,80; then a valid ADD frame is answered correctly
//  Timeout: 00,34 then TIMEOUT_CYC idle cycles -> one Frame_Err_out pulse, Busy_out=0, no Tx;
//   next full frame answered correctly
//  Reset during SEND after first byte -> Tx_DV_out=0, Busy_out=0 at once; no further bytes sent

Source files
------------

// File: rtl/uart_alu_core.sv
// UART-fed multi-byte ALU: collects opcode + two DATA_W-bit operands, executes one op,
// and streams back the result bytes (LSB first) followed by a status byte.
module uart_alu_core #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Rx_Byte_in,
  input  logic       Rx_DV_in,
  input  logic       Tx_Done_in,
  output logic       Tx_DV_out,
  output logic [7:0] Tx_Byte_out,
  output logic       Busy_out,
  output logic       Frame_Err_out,
  output logic [7:0] c_out
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (2 * NB > 1) ? $clog2(2 * NB) : 1;
  localparam int SW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, RECV, EXE, SEND} state_t;

  state_t                  state_r;
  logic [7:0]              op_r;
  logic [2*DATA_W-1:0]     ab_r;
  logic [CW-1:0]           byte_cnt_r;
  logic [TW-1:0]           tmo_cnt_r;
  logic [DATA_W+7:0]       tx_sr_r;
  logic [SW-1:0]           snd_cnt_r;
  logic                    snd_wait_r;
  logic                    busy_r;
  logic                    tx_dv_r;
  logic [7:0]              tx_byte_r;
  logic                    frame_err_r;
  logic [7:0]              c_r;
  logic [DATA_W+7:0]       alu_s;

  // Returns {status, result}; status = {badop, 4'b0, ovf, carry, zero}.
  function automatic logic [DATA_W+7:0] alu_f(input logic [7:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum_v;
    logic [DATA_W-1:0] res_v;
    logic              cy_v, ov_v, bad_v, zero_v;
    sum_v = {1'b0, a} + {1'b0, b};
    res_v = '0;
    cy_v  = 1'b0;
    ov_v  = 1'b0;
    bad_v = 1'b0;
    case (op)
      8'h00: begin
        res_v = sum_v[DATA_W-1:0];
        cy_v  = sum_v[DATA_W];
        ov_v  = (a[DATA_W-1] == b[DATA_W-1]) && (res_v[DATA_W-1] != a[DATA_W-1]);
      end
      8'h01: begin
        res_v = a - b;
        cy_v  = (a >= b);
        ov_v  = (a[DATA_W-1] != b[DATA_W-1]) && (res_v[DATA_W-1] != a[DATA_W-1]);
      end
      8'h02: res_v = a & b;
      8'h03: res_v = a | b;
      8'h04: res_v = a ^ b;
      8'h05: begin
        ov_v = (a[DATA_W-1] == b[DATA_W-1]) && (sum_v[DATA_W-1] != a[DATA_W-1]);
        if (!ov_v) begin
          res_v = sum_v[DATA_W-1:0];
        end else if (a[DATA_W-1]) begin
          res_v = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
          res_v = {1'b0, {(DATA_W-1){1'b1}}};
        end
      end
      default: bad_v = 1'b1;
    endcase
    zero_v = !bad_v && (res_v == '0);
    return {bad_v, 4'b0000, ov_v, cy_v, zero_v, res_v};
  endfunction

  // Operands sit LSB-byte-first in ab_r: A in the low half, B in the high half.
  always_comb begin
    alu_s = alu_f(op_r, ab_r[DATA_W-1:0], ab_r[2*DATA_W-1:DATA_W]);
  end

  // Frame receive / execute / transmit sequencer with registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      op_r        <= 8'h00;
      ab_r        <= '0;
      byte_cnt_r  <= '0;
      tmo_cnt_r   <= '0;
      tx_sr_r     <= '0;
      snd_cnt_r   <= '0;
      snd_wait_r  <= 1'b0;
      busy_r      <= 1'b0;
      tx_dv_r     <= 1'b0;
      tx_byte_r   <= 8'h00;
      frame_err_r <= 1'b0;
      c_r         <= 8'h00;
    end else begin
      tx_dv_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Rx_DV_in) begin
            op_r       <= Rx_Byte_in;
            byte_cnt_r <= '0;
            tmo_cnt_r  <= '0;
            busy_r     <= 1'b1;
            state_r    <= RECV;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RECV: begin
          // A byte arriving on the threshold cycle takes priority over the abort.
          if (Rx_DV_in) begin
            ab_r       <= {Rx_Byte_in, ab_r[2*DATA_W-1:8]};
            tmo_cnt_r  <= '0;
            byte_cnt_r <= byte_cnt_r + CW'(1);
            if (byte_cnt_r == CW'(2 * NB - 1)) begin
              state_r <= EXE;
            end else begin
              state_r <= RECV;
            end
          end else if (tmo_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
            ab_r        <= '0;
            byte_cnt_r  <= '0;
            tmo_cnt_r   <= '0;
            frame_err_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        EXE: begin
          tx_sr_r    <= alu_s;
          c_r        <= alu_s[7:0];
          snd_cnt_r  <= '0;
          snd_wait_r <= 1'b0;
          state_r    <= SEND;
        end
        SEND: begin
          if (!snd_wait_r) begin
            tx_dv_r    <= 1'b1;
            tx_byte_r  <= tx_sr_r[7:0];
            snd_wait_r <= 1'b1;
          end else if (Tx_Done_in) begin
            snd_wait_r <= 1'b0;
            tx_sr_r    <= {8'h00, tx_sr_r[DATA_W+7:8]};
            if (snd_cnt_r == SW'(NB)) begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              snd_cnt_r <= snd_cnt_r + SW'(1);
            end
          end else begin
            snd_wait_r <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Tx_DV_out     = tx_dv_r;
  assign Tx_Byte_out   = tx_byte_r;
  assign Busy_out      = busy_r;
  assign Frame_Err_out = frame_err_r;
  assign c_out         = c_r;

endmodule

// File: tb/tb_uart_alu_core.sv
// Scoreboard bench for uart_alu_core: randomized frames checked against an integer reference model.
module tb_uart_alu_core;

  localparam int TMO = 200;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] Rx_Byte_in = 8'h00;
  logic       Rx_DV_in = 1'b0;
  logic       Tx_Done_in = 1'b0;
  logic       Tx_DV_out;
  logic [7:0] Tx_Byte_out;
  logic       Busy_out;
  logic       Frame_Err_out;
  logic [7:0] c_out;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_alu_core #(.DATA_W(16), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .Rx_Byte_in(Rx_Byte_in), .Rx_DV_in(Rx_DV_in),
    .Tx_Done_in(Tx_Done_in), .Tx_DV_out(Tx_DV_out), .Tx_Byte_out(Tx_Byte_out),
    .Busy_out(Busy_out), .Frame_Err_out(Frame_Err_out), .c_out(c_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic over 16-bit operands; returns {status, result}.
  function automatic logic [23:0] ref_alu(input logic [7:0] op, input int a, input int b);
    int r, sa, sb, ss;
    bit cy, ov, bad;
    logic [7:0] st;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    r = 0; cy = 1'b0; ov = 1'b0; bad = 1'b0;
    case (op)
      8'h00: begin r = (a + b) % 65536; cy = (a + b) > 65535; ss = sa + sb; ov = (ss > 32767) || (ss < -32768); end
      8'h01: begin r = (a - b + 65536) % 65536; cy = (a >= b); ss = sa - sb; ov = (ss > 32767) || (ss < -32768); end
      8'h02: r = a & b;
      8'h03: r = a | b;
      8'h04: r = a ^ b;
      8'h05: begin
        ss = sa + sb;
        if (ss > 32767) begin r = 32767; ov = 1'b1; end
        else if (ss < -32768) begin r = 32768; ov = 1'b1; end
        else r = (ss + 65536) % 65536;
      end
      default: bad = 1'b1;
    endcase
    st = {bad, 4'b0000, ov, cy, (!bad && r == 0)};
    return {st, r[15:0]};
  endfunction

  // Monitor: every Tx_DV_out pulse must match the head of the expected queue.
  always @(negedge CLK) begin
    if (RST && Frame_Err_out) err_cnt++;
    if (RST && Tx_DV_out) begin
      if (exp_q.size() == 0) check("unexpected_tx", int'(Tx_Byte_out), -1);
      else check("tx_byte", int'(Tx_Byte_out), int'(exp_q.pop_front()));
    end
  end

  // Transmitter model: Tx_Done about 5 cycles after each Tx_DV; no new Tx_DV allowed meanwhile.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && Tx_DV_out) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge CLK);
          if (Tx_DV_out) check("dv_before_done", 1, 0);
        end
        @(posedge CLK); #1 Tx_Done_in = 1'b1;
        @(posedge CLK); #1 Tx_Done_in = 1'b0;
      end
    end
  end

  // Called just after a posedge; byte is sampled gap+1 edges later.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge CLK);
    #1;
    Rx_Byte_in = b; Rx_DV_in = 1'b1;
    @(posedge CLK); #1;
    Rx_DV_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy_out || exp_q.size() != 0) && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 400) check("idle_timeout", n, 0);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                           input int gap, input bit lat);
    logic [23:0] e;
    e = ref_alu(op, int'(a), int'(b));
    exp_q.push_back(e[7:0]); exp_q.push_back(e[15:8]); exp_q.push_back(e[23:16]);
    send_byte(op, 0);
    send_byte(a[7:0], gap); send_byte(a[15:8], gap);
    send_byte(b[7:0], gap); send_byte(b[15:8], gap);
    if (lat) begin
      @(posedge CLK); #1 check("lat_n1", int'(Tx_DV_out), 0);
      @(posedge CLK); #1 check("lat_n2", int'(Tx_DV_out), 1);
    end
    wait_idle();
    check("c_out", int'(c_out), int'(e[7:0]));
  endtask

  initial begin
    logic [7:0]  op;
    logic [15:0] a, b;
    int e0;
    #12;
    check("rst_tx_dv", int'(Tx_DV_out), 0);
    check("rst_tx_byte", int'(Tx_Byte_out), 0);
    check("rst_busy", int'(Busy_out), 0);
    check("rst_ferr", int'(Frame_Err_out), 0);
    check("rst_c_out", int'(c_out), 0);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1;

    run_frame(8'h00, 16'h1234, 16'h0001, 0, 1'b1);
    run_frame(8'h00, 16'hFFFF, 16'h0001, 1, 1'b0);
    run_frame(8'h05, 16'h7FF0, 16'h0100, 2, 1'b0);
    run_frame(8'h01, 16'h0005, 16'h0007, 0, 1'b0);
    run_frame(8'h09, 16'h2211, 16'h4433, 0, 1'b0);
    run_frame(8'h00, 16'h0102, 16'h0304, 3, 1'b0);
    run_frame(8'h05, 16'h8000, 16'hFFFF, 0, 1'b0);
    // Byte lands exactly on the timeout threshold cycle: must be accepted.
    e0 = err_cnt;
    run_frame(8'h04, 16'hA5A5, 16'h5A5A, TMO - 1, 1'b0);
    check("no_abort_at_threshold", err_cnt, e0);

    // Partial frame then silence: one framing error, no transmit.
    e0 = err_cnt;
    send_byte(8'h00, 0); send_byte(8'h34, 0);
    repeat (TMO + 10) @(posedge CLK);
    #1;
    check("timeout_err_cnt", err_cnt, e0 + 1);
    check("timeout_busy", int'(Busy_out), 0);
    run_frame(8'h00, 16'h1234, 16'h0001, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 8'(32'($urandom_range(6, 255))) : 8'(32'($urandom_range(0, 5)));
      case ($urandom_range(0, 3))
        0: a = 16'h7FFF;
        1: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      b = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      run_frame(op, a, b, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset after the first result byte: nothing further may be sent.
    exp_q.push_back(8'h35);
    send_byte(8'h00, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge CLK);
    check("first_byte_seen", exp_q.size(), 0);
    @(posedge CLK); #1 RST = 1'b0;
    #1;
    check("midrst_tx_dv", int'(Tx_DV_out), 0);
    check("midrst_busy", int'(Busy_out), 0);
    check("midrst_c_out", int'(c_out), 0);
    @(posedge CLK); #1 RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check("post_rst_busy", int'(Busy_out), 0);
    run_frame(8'h03, 16'h0F00, 16'h00F0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
